event_scheduler: RTL and testbench
==================================

# event_scheduler

Front-end sequencer for the launchpad event path. It synchronizes raw pad buttons and detects their rising edges. Simultaneous presses are arbitrated round-robin into a small event queue. Queued events are dispatched to the LED and RGB handlers as spaced, one-cycle, one-hot event pulses, so no handler ever sees two events closer than a programmed gap.

## Interface
Parameters:
- N_EVT, 12, number of pad/event lines (event index 0..N_EVT-1).
- DEPTH, 4, event queue depth (power of two, ≥2).
- GAP_CYC, 4, idle cycles inserted after every dispatched pulse (≥1).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- btn_in  in  N_EVT  raw pad levels, asynchronous to CLK.
- hold  in  1  when 1, dispatch paused; queueing continues.
- ovf_clr  in  1  synchronous clear of sticky overflow.
- ev_out  out  N_EVT  one-hot event pulse to handlers; 0 when idle.
- ev_id  out  $clog2(N_EVT)  index of current pulse; valid while ev_valid.
- ev_valid  out  1  OR of ev_out.
- fifo_cnt  out  $clog2(DEPTH)+1  queue occupancy.
- overflow  out  1  sticky: a press was merged/lost.
- busy  out  1  any pending bit, non-empty queue, or FSM not IDLE.

## Operation
- Input stage: per line 2-flop synchronizer (s1, s2) plus history flop prv. All three reset to 1, so a button held through reset does not fire until it is released and pressed again. The edge signal is s2 & ~prv.
- Pending register: a bit is set on an edge and cleared on grant. If an edge arrives on a bit that is already pending, the edges merge, the bit stays 1, and overflow is set.
- Arbiter: round-robin over pending bits, searching from last_grant+1 upward with wrap. last_grant resets to N_EVT-1, so bit 0 has first priority. It grants at most one bit per cycle, and only when the registered queue is not full. When full, pending bits hold.
- Queue: FIFO of event indices.
  - Push is the grant.
  - Pop happens on the IDLE→FIRE transition.
  - Push and pop in the same cycle are allowed when the queue is non-full; fifo_cnt is unchanged.
- Dispatch FSM, states IDLE, FIRE, GAP:
  - IDLE: if the queue is non-empty and hold=0, pop the head, load it into the id register, and go to FIRE.
  - FIRE: ev_out = 1<<id, ev_valid=1, ev_id=id. Load the gap counter with GAP_CYC-1 and go to GAP.
  - GAP: decrement the counter; when it reaches 0, go to IDLE. hold is ignored here.
- overflow: set by a merge and cleared by ovf_clr. If both occur in the same cycle, the set wins.
- Reset values: ev_out=0, ev_id=0, ev_valid=0, fifo_cnt=0, overflow=0, busy=0, state=IDLE, pending=0, queue pointers=0. Reset asserted mid-operation drops all queued and pending events.

## Timing
Clock edges are numbered from E0, the first edge that samples btn_in high.
- E1: s2 rises. E2: pending bit set. E3: queue write. E4: FSM enters FIRE.
- With an idle FSM, empty queue and hold=0, ev_out is high from E4 to E5. Latency is 4 cycles; pulse width is exactly 1 cycle.
- Back-to-back queued events: pulses start every GAP_CYC+2 cycles (FIRE, GAP_CYC×GAP, IDLE).
- ev_out, ev_id and ev_valid are registered (state-decoded from flops); there is no combinational path from inputs.
- Releasing hold: first pulse comes 1 cycle after the IDLE cycle that samples hold=0.

## Structure
- Package event_sched_pkg holds:
  - the state enum {IDLE, FIRE, GAP};
  - the default N_EVT;
  - the index-width function.
- Sub-module event_fifo is parameterized by width and DEPTH. It provides push, pop, dout, full, empty and count, and is reused for the index queue.
- Synchronizer, pending register, arbiter and FSM live in event_scheduler.

## Test plan
- Single press of line 3 from idle: ev_out=12'h008 for exactly 1 cycle, starting 4 edges after the sampling edge; ev_id=3; fifo_cnt returns to 0.
- Lines 0, 5 and 9 pressed in the same cycle, GAP_CYC=4: pulses in order 0, 5, 9, spaced 6 cycles apart; overflow=0.
- Round-robin fairness: line 2 granted first, then lines 1 and 7 pressed together. Order is 7 then 1, because the search starts from last_grant+1.
- Overflow path with DEPTH=4 and hold=1:
  - press lines 0..4 once: 4 enqueued, line 4 stays pending;
  - press line 4 again: overflow=1;
  - release hold: 5 pulses total;
  - ovf_clr: overflow returns to 0.
- Reset behaviour:
  - btn_in[6] held high across reset release: no pulse until release and re-press;
  - RST asserted during GAP with 2 events queued: all outputs go to 0 immediately, and no pulses follow after release.

Source files
------------

// File: rtl/event_sched_pkg.sv
// Shared types and helpers for the launchpad event scheduler.
package event_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int N_EVT_DEF = 12;

  // Width needed to hold an index in 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO; push and pop may coincide whenever the FIFO is not full.
module event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (cnt_r == CW'(DEPTH));
  assign empty     = (cnt_r == {CW{1'b0}});
  assign count     = cnt_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/event_scheduler.sv
// Pad-button front end: synchronize, edge-detect, round-robin arbitrate into a
// queue, then dispatch spaced one-hot event pulses.
module event_scheduler
  import event_sched_pkg::*;
#(
  parameter int N_EVT   = N_EVT_DEF,
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_EVT-1:0]          btn_in,
  input  logic                      hold,
  input  logic                      ovf_clr,
  output logic [N_EVT-1:0]          ev_out,
  output logic [idx_w(N_EVT)-1:0]   ev_id,
  output logic                      ev_valid,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      overflow,
  output logic                      busy
);

  localparam int IW = idx_w(N_EVT);
  localparam int GW = idx_w(GAP_CYC) + 1;
  localparam logic [N_EVT-1:0] ONE_HOT0 = N_EVT'(1);

  logic [N_EVT-1:0] s1_r, s2_r, prv_r, pend_r;
  logic [N_EVT-1:0] edge_s, grant_s, merge_s, pend_n_s;
  logic [IW-1:0]    last_grant_r, grant_idx_s, f_dout_s;
  logic             grant_vld_s, arb_hit_s;
  int               arb_idx_s;
  state_e           state_r, state_n_s;
  logic [GW-1:0]    gap_r, gap_n_s;
  logic             f_pop_s, f_full_s, f_empty_s;
  logic [N_EVT-1:0] ev_out_r;
  logic [IW-1:0]    ev_id_r;
  logic             ev_valid_r, overflow_r;

  // Synchronizer and history flops reset high so a button held through reset stays quiet.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_r  <= {N_EVT{1'b1}};
      s2_r  <= {N_EVT{1'b1}};
      prv_r <= {N_EVT{1'b1}};
    end else begin
      s1_r  <= btn_in;
      s2_r  <= s1_r;
      prv_r <= s2_r;
    end
  end

  assign edge_s = s2_r & ~prv_r;

  // Round-robin search starting just above the last granted line.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    arb_idx_s   = 0;
    arb_hit_s   = 1'b0;
    for (int i = 0; i < N_EVT; i++) begin
      arb_idx_s   = (int'(last_grant_r) + 1 + i) % N_EVT;
      arb_hit_s   = !grant_vld_s && pend_r[arb_idx_s] && !f_full_s;
      grant_idx_s = arb_hit_s ? IW'(arb_idx_s) : grant_idx_s;
      grant_vld_s = grant_vld_s | arb_hit_s;
    end
  end

  assign grant_s  = grant_vld_s ? (ONE_HOT0 << grant_idx_s) : {N_EVT{1'b0}};
  assign merge_s  = edge_s & pend_r & ~grant_s;
  assign pend_n_s = (pend_r & ~grant_s) | edge_s;

  // Pending bits, arbiter pointer and sticky overflow; a merge beats a clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_r       <= {N_EVT{1'b0}};
      last_grant_r <= IW'(N_EVT - 1);
      overflow_r   <= 1'b0;
    end else begin
      pend_r <= pend_n_s;
      if (grant_vld_s) begin
        last_grant_r <= grant_idx_s;
      end
      if (|merge_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  event_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (grant_vld_s),
    .pop   (f_pop_s),
    .din   (grant_idx_s),
    .dout  (f_dout_s),
    .full  (f_full_s),
    .empty (f_empty_s),
    .count (fifo_cnt)
  );

  // Dispatch FSM next state; hold only matters while idle.
  always_comb begin
    state_n_s = state_r;
    gap_n_s   = gap_r;
    f_pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!f_empty_s && !hold) begin
          state_n_s = FIRE;
          f_pop_s   = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      FIRE: begin
        state_n_s = GAP;
        gap_n_s   = GW'(GAP_CYC - 1);
      end
      GAP: begin
        if (gap_r == {GW{1'b0}}) begin
          state_n_s = IDLE;
        end else begin
          gap_n_s = gap_r - GW'(1);
        end
      end
      default: begin
        state_n_s = IDLE;
        gap_n_s   = {GW{1'b0}};
      end
    endcase
  end

  // FSM state, gap counter and registered pulse outputs loaded on entry to FIRE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      gap_r      <= {GW{1'b0}};
      ev_out_r   <= {N_EVT{1'b0}};
      ev_id_r    <= {IW{1'b0}};
      ev_valid_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      gap_r   <= gap_n_s;
      if (f_pop_s) begin
        ev_out_r   <= ONE_HOT0 << f_dout_s;
        ev_id_r    <= f_dout_s;
        ev_valid_r <= 1'b1;
      end else begin
        ev_out_r   <= {N_EVT{1'b0}};
        ev_valid_r <= 1'b0;
      end
    end
  end

  assign ev_out   = ev_out_r;
  assign ev_id    = ev_id_r;
  assign ev_valid = ev_valid_r;
  assign overflow = overflow_r;
  assign busy     = (|pend_r) || !f_empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_event_scheduler.sv
// Scoreboard bench for event_scheduler: stimulus queues expected event ids,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_event_scheduler;

  localparam int GAP = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] btn_in = 12'h000;
  logic        hold = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [11:0] ev_out;
  logic [3:0]  ev_id;
  logic        ev_valid;
  logic [2:0]  fifo_cnt;
  logic        overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int cyc = 0;
  int last_pulse = -1;
  bit chk_spacing = 1'b0;
  bit prev_valid = 1'b0;
  int n_pulses = 0;
  int p0;

  event_scheduler #(.N_EVT(12), .DEPTH(4), .GAP_CYC(GAP)) dut (
    .CLK(CLK), .RST(RST), .btn_in(btn_in), .hold(hold), .ovf_clr(ovf_clr),
    .ev_out(ev_out), .ev_id(ev_id), .ev_valid(ev_valid), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge CLK) begin : mon
    int e;
    if (ev_valid || ev_out != 12'h000) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got ev_out=%0h ev_id=%0d expected none", ev_out, ev_id);
      end else begin
        e = exp_q.pop_front();
        check("pulse_out", 32'(ev_out), 32'(1) << e);
        check("pulse_id", 32'(ev_id), 32'(e));
        check("pulse_valid", 32'(ev_valid), 32'd1);
        check("pulse_width", 32'(prev_valid), 32'd0);
        if (chk_spacing && last_pulse >= 0) begin
          check("pulse_spacing", 32'(cyc - last_pulse), 32'(GAP + 2));
        end
      end
      last_pulse = cyc;
      n_pulses++;
    end
    prev_valid = ev_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 300) begin
      tick(1);
      k++;
    end
    check({name, "_drain"}, 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(2);
    check("rst_ev_out", 32'(ev_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    RST = 1'b1;
    tick(3);
    check("idle_ev_out", 32'(ev_out), 32'h0);
    check("idle_ev_id", 32'(ev_id), 32'h0);
    check("idle_ev_valid", 32'(ev_valid), 32'h0);
    check("idle_fifo_cnt", 32'(fifo_cnt), 32'h0);
    check("idle_overflow", 32'(overflow), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // lines 0, 5, 9 together: order 0,5,9, six cycles apart
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(9);
    p0 = n_pulses;
    last_pulse = -1;
    chk_spacing = 1'b1;
    btn_in = 12'h221;
    wait_idle("multi");
    chk_spacing = 1'b0;
    check("multi_count", 32'(n_pulses - p0), 32'd3);
    check("multi_ovf", 32'(overflow), 32'd0);
    btn_in = 12'h000;
    tick(4);

    // single press of line 3: pulse on E4 for exactly one cycle
    exp_q.push_back(3);
    btn_in = 12'h008;
    tick(1);
    tick(3);
    check("single_e3_valid", 32'(ev_valid), 32'd0);
    check("single_e3_cnt", 32'(fifo_cnt), 32'd1);
    tick(1);
    check("single_e4_out", 32'(ev_out), 32'h008);
    check("single_e4_id", 32'(ev_id), 32'd3);
    tick(1);
    check("single_e5_valid", 32'(ev_valid), 32'd0);
    wait_idle("single");
    check("single_cnt", 32'(fifo_cnt), 32'd0);
    btn_in = 12'h000;
    tick(4);

    // round robin: grant 2, then 7 before 1
    exp_q.push_back(2);
    btn_in = 12'h004;
    wait_idle("rr_first");
    btn_in = 12'h000;
    tick(4);
    exp_q.push_back(7); exp_q.push_back(1);
    btn_in = 12'h082;
    wait_idle("rr_pair");
    btn_in = 12'h000;
    tick(4);

    // overflow: queue full under hold, line 4 pending then merged
    do_reset();
    hold = 1'b1;
    btn_in = 12'h01F;
    tick(10);
    check("ovf_full_cnt", 32'(fifo_cnt), 32'd4);
    check("ovf_before", 32'(overflow), 32'd0);
    check("ovf_busy", 32'(busy), 32'd1);
    btn_in[4] = 1'b0;
    tick(3);
    btn_in[4] = 1'b1;
    tick(5);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt_hold", 32'(fifo_cnt), 32'd4);
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    p0 = n_pulses;
    last_pulse = -1;
    chk_spacing = 1'b1;
    hold = 1'b0;
    tick(1);
    check("hold_release_valid", 32'(ev_valid), 32'd1);
    wait_idle("ovf_drain");
    chk_spacing = 1'b0;
    check("ovf_pulses", 32'(n_pulses - p0), 32'd5);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    btn_in = 12'h000;
    tick(4);

    // line 6 held across reset: quiet until released and pressed again
    btn_in = 12'h040;
    p0 = n_pulses;
    do_reset();
    tick(10);
    check("held_quiet_busy", 32'(busy), 32'd0);
    check("held_quiet_pulses", 32'(n_pulses - p0), 32'd0);
    btn_in = 12'h000;
    tick(3);
    exp_q.push_back(6);
    btn_in = 12'h040;
    wait_idle("held_repress");
    btn_in = 12'h000;
    tick(4);

    // reset during GAP with two events queued
    exp_q.push_back(0);
    p0 = n_pulses;
    btn_in = 12'h007;
    tick(6);
    check("gap_cnt_before", 32'(fifo_cnt), 32'd2);
    RST = 1'b0;
    #1;
    check("gaprst_ev_out", 32'(ev_out), 32'h0);
    check("gaprst_valid", 32'(ev_valid), 32'h0);
    check("gaprst_cnt", 32'(fifo_cnt), 32'h0);
    check("gaprst_busy", 32'(busy), 32'h0);
    tick(2);
    RST = 1'b1;
    tick(20);
    check("gaprst_after_busy", 32'(busy), 32'd0);
    check("gaprst_pulses", 32'(n_pulses - p0), 32'd1);
    btn_in = 12'h000;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
